truth_table_scanner: RTL and testbench

//  Sequential stimulus/capture stage sitting directly upstream of a combinational
//  N-input function block (sum-of-products style, inputs x,y,w,z, output s).
//  On start it sweeps all 2^N input vectors in ascending minterm order and drives

---
 rtl/truth_table_scanner.sv | 140 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_scanner
//  Purpose  : Sweeps all 2^N_IN input vectors in ascending minterm order into a
//             downstream combinational function, samples its output for each
//             vector, and builds the captured truth table (mask). It also counts
//             the ones in the mask and compares the mask against an expected table.
//  Ports    : clk        - rising-edge clock
//             reset      - synchronous, active-high
//             start      - one-cycle sweep request (honoured only in IDLE)
//             f_in       - output of the function under scan
//             exp_mask   - expected truth table, bit i = f(minterm i)
//             vec_out    - registered input vector (bit N_IN-1 = x .. bit 0 = z)
//             busy       - high while sweeping
//             done       - one-cycle completion pulse
//             mask       - captured truth table
//             ones_cnt   - number of ones in mask
//             mask_valid - mask/ones_cnt/match final, held until next start
//             match      - mask == exp_mask (meaningful while mask_valid)
//  Revision : 1.0 - initial release
// ============================================================================
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    f_in,
    input  logic [(1<<N_IN)-1:0]    exp_mask,
    output logic [N_IN-1:0]         vec_out,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<N_IN)-1:0]    mask,
    output logic [N_IN:0]           ones_cnt,
    output logic                    mask_valid,
    output logic                    match
);

    localparam int              c_NVEC   = 1 << N_IN;
    localparam logic [N_IN-1:0] c_LAST   = '1;
    localparam logic [2:0]      c_SETTLE = 3'(SETTLE);
    localparam logic [N_IN-1:0] c_IDX_ONE = {{(N_IN-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [N_IN-1:0]   r_idx;
    logic [2:0]        r_settle;
    logic              r_busy;
    logic              r_done;
    logic [c_NVEC-1:0] r_mask;
    logic [N_IN:0]     r_ones;
    logic              r_valid;
    logic              r_match;

    logic              w_sample;
    logic              w_last;
    logic [c_NVEC-1:0] w_mask_next;

    // The sample edge is the one closing the last settle cycle of a vector.
    assign w_sample = (r_state == S_SCAN) && (r_settle == c_SETTLE);
    assign w_last   = (r_idx == c_LAST);
    // mask is cleared at start, so OR-ing the current bit in is sufficient.
    assign w_mask_next = r_mask | ({{(c_NVEC-1){1'b0}}, f_in} << r_idx);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SCAN;
            S_SCAN:  if (w_sample && w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mask   <= '0;
            r_ones   <= '0;
            r_valid  <= 1'b0;
            r_match  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_idx    <= '0;
                        r_settle <= '0;
                        r_mask   <= '0;
                        r_ones   <= '0;
                        r_valid  <= 1'b0;
                        r_match  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_sample) begin
                        r_mask   <= w_mask_next;
                        r_ones   <= r_ones + {{N_IN{1'b0}}, f_in};
                        r_settle <= '0;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_valid <= 1'b1;
                            // exp_mask is only consulted here, on the final sample.
                            r_match <= (w_mask_next == exp_mask);
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end else begin
                        r_settle <= r_settle + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // vec_out is the index register itself, so it is fully registered.
    assign vec_out    = r_idx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign mask       = r_mask;
    assign ones_cnt   = r_ones;
    assign mask_valid = r_valid;
    assign match      = r_match;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_truth_table_scanner
//  Purpose  : Self-checking bench for truth_table_scanner. Three instances
//             (N_IN=3/SETTLE=0, N_IN=4/SETTLE=2, N_IN=4/SETTLE=0) are driven by
//             a table of sweeps, random sweeps against a reference model, and
//             hand sequences for reset corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_scanner;

    logic clk;
    logic reset;

    logic        start_c [3];
    logic [15:0] fmask_c [3];
    logic [15:0] exp_c   [3];
    logic        noise_c [3];
    logic [3:0]  vec_c   [3];
    logic        busy_c  [3];
    logic        done_c  [3];
    logic [15:0] mask_c  [3];
    logic [4:0]  ones_c  [3];
    logic        valid_c [3];
    logic        match_c [3];

    int nin  [3] = '{3, 4, 4};
    int sset [3] = '{0, 2, 0};

    int total = 0;
    int bad   = 0;

    // Instance 0: N_IN=3, SETTLE=0
    logic [2:0] vec_a;
    logic [7:0] mask_a;
    logic [3:0] ones_a;
    logic       f_a;
    assign f_a       = fmask_c[0][vec_a] ^ noise_c[0];
    assign vec_c[0]  = {1'b0, vec_a};
    assign mask_c[0] = {8'h00, mask_a};
    assign ones_c[0] = {1'b0, ones_a};

    truth_table_scanner #(.N_IN(3), .SETTLE(0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_c[0]), .f_in(f_a),
        .exp_mask(exp_c[0][7:0]), .vec_out(vec_a), .busy(busy_c[0]),
        .done(done_c[0]), .mask(mask_a), .ones_cnt(ones_a),
        .mask_valid(valid_c[0]), .match(match_c[0])
    );

    // Instance 1: N_IN=4, SETTLE=2
    logic f_b;
    assign f_b = fmask_c[1][vec_c[1]] ^ noise_c[1];

    truth_table_scanner #(.N_IN(4), .SETTLE(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_c[1]), .f_in(f_b),
        .exp_mask(exp_c[1]), .vec_out(vec_c[1]), .busy(busy_c[1]),
        .done(done_c[1]), .mask(mask_c[1]), .ones_cnt(ones_c[1]),
        .mask_valid(valid_c[1]), .match(match_c[1])
    );

    // Instance 2: N_IN=4, SETTLE=0
    logic f_c;
    assign f_c = fmask_c[2][vec_c[2]] ^ noise_c[2];

    truth_table_scanner #(.N_IN(4), .SETTLE(0)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c[2]), .f_in(f_c),
        .exp_mask(exp_c[2]), .vec_out(vec_c[2]), .busy(busy_c[2]),
        .done(done_c[2]), .mask(mask_c[2]), .ones_cnt(ones_c[2]),
        .mask_valid(valid_c[2]), .match(match_c[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] fm;
        logic [15:0] em;
        int          restart_at;
        bit          start_in_done;
        logic [15:0] x_mask;
        int          x_ones;
        bit          x_match;
        int          x_busy;
    } sweep_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Reference: the captured table is the function's truth table restricted to
    // 2^N minterms; busy lasts one vector period per minterm.
    function automatic sweep_t model(input int id, input logic [15:0] fm,
                                     input logic [15:0] em, input int restart_at);
        sweep_t      s;
        int          nv = 1 << nin[id];
        logic [15:0] em_t = '0;
        s.id = id; s.fm = fm; s.em = em; s.restart_at = restart_at;
        s.start_in_done = 1'b0;
        s.x_mask = '0; s.x_ones = 0;
        for (int i = 0; i < nv; i++) begin
            em_t[i] = em[i];
            if (fm[i]) begin
                s.x_mask[i] = 1'b1;
                s.x_ones++;
            end
        end
        s.x_match = (s.x_mask == em_t);
        s.x_busy  = nv * (sset[id] + 1);
        return s;
    endfunction

    // Called at a negedge with the instance idle.
    task automatic do_sweep(input sweep_t v);
        int id      = v.id;
        int per     = sset[id] + 1;
        int cyc     = 0;
        int seq_bad = 0;
        fmask_c[id] = v.fm;
        exp_c[id]   = v.em;
        noise_c[id] = 1'b0;
        start_c[id] = 1'b1;
        @(negedge clk);
        start_c[id] = 1'b0;
        while (busy_c[id] === 1'b1 && cyc < 200) begin
            if (vec_c[id] !== 4'(cyc / per)) seq_bad++;
            if (done_c[id] !== 1'b0) seq_bad++;
            if (cyc == 0 && (valid_c[id] !== 1'b0 || mask_c[id] !== 16'h0 ||
                             ones_c[id] !== 5'd0 || match_c[id] !== 1'b0)) seq_bad++;
            start_c[id] = (cyc == v.restart_at);
            // Garbage on f_in away from sample edges, and on exp_mask before the last one.
            noise_c[id] = (cyc % per != per - 1) ? 1'($urandom) : 1'b0;
            exp_c[id]   = (cyc < v.x_busy - 1) ? 16'($urandom) : v.em;
            @(negedge clk);
            cyc++;
        end
        start_c[id] = 1'b0;
        noise_c[id] = 1'b0;
        exp_c[id]   = v.em;
        chk("busy_len", cyc, v.x_busy);
        chk("vec_seq_errs", seq_bad, 0);
        chk("done_pulse", {31'd0, done_c[id]}, 1);
        chk("mask", {16'd0, mask_c[id]}, {16'd0, v.x_mask});
        chk("ones_cnt", {27'd0, ones_c[id]}, v.x_ones);
        chk("mask_valid", {31'd0, valid_c[id]}, 1);
        chk("match", {31'd0, match_c[id]}, {31'd0, v.x_match});
        chk("vec_idle", {28'd0, vec_c[id]}, 0);
        start_c[id] = v.start_in_done;
        @(negedge clk);
        start_c[id] = 1'b0;
        chk("done_clear", {31'd0, done_c[id]}, 0);
        chk("busy_after", {31'd0, busy_c[id]}, 0);
        chk("mask_hold", {16'd0, mask_c[id]}, {16'd0, v.x_mask});
        chk("valid_hold", {31'd0, valid_c[id]}, 1);
    endtask

    task automatic chk_reset_state(input int id);
        chk("rst_vec",   {28'd0, vec_c[id]},   0);
        chk("rst_busy",  {31'd0, busy_c[id]},  0);
        chk("rst_done",  {31'd0, done_c[id]},  0);
        chk("rst_mask",  {16'd0, mask_c[id]},  0);
        chk("rst_ones",  {27'd0, ones_c[id]},  0);
        chk("rst_valid", {31'd0, valid_c[id]}, 0);
        chk("rst_match", {31'd0, match_c[id]}, 0);
    endtask

    sweep_t table_v[8];

    initial begin
        //                id  fm        em        rst  sid  x_mask    ones mt busy
        table_v[0] = '{0, 16'h0066, 16'h0066, -1, 1'b0, 16'h0066, 4,  1, 8};
        table_v[1] = '{0, 16'h00AA, 16'h00AA, -1, 1'b0, 16'h00AA, 4,  1, 8};
        table_v[2] = '{0, 16'h00AA, 16'h00AB, -1, 1'b1, 16'h00AA, 4,  0, 8};
        table_v[3] = '{2, 16'h5545, 16'h5545, -1, 1'b0, 16'h5545, 7,  1, 16};
        table_v[4] = '{1, 16'h0A43, 16'h0A43, -1, 1'b0, 16'h0A43, 5,  1, 48};
        table_v[5] = '{2, 16'hFFFF, 16'hFFFF,  5, 1'b0, 16'hFFFF, 16, 1, 16};
        table_v[6] = '{2, 16'h0000, 16'h0000, -1, 1'b1, 16'h0000, 0,  1, 16};
        table_v[7] = '{1, 16'hFFFF, 16'hFFFE, 20, 1'b0, 16'hFFFF, 16, 0, 48};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_c[i] = 1'b0; fmask_c[i] = '0; exp_c[i] = '0; noise_c[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset_state(i);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 8; t++) do_sweep(table_v[t]);

        // Reset in the middle of a sweep: no done, partial mask discarded.
        begin
            int seen_done = 0;
            fmask_c[2] = 16'hFFFF; exp_c[2] = 16'hFFFF;
            start_c[2] = 1'b1;
            @(negedge clk);
            start_c[2] = 1'b0;
            repeat (7) @(negedge clk);
            chk("pre_rst_busy", {31'd0, busy_c[2]}, 1);
            reset = 1'b1;
            @(negedge clk);
            chk_reset_state(2);
            reset = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (done_c[2] !== 1'b0 || busy_c[2] !== 1'b0) seen_done++;
                @(negedge clk);
            end
            chk("rst_no_done", seen_done, 0);
        end
        do_sweep(model(2, 16'h1234, 16'h1234, -1));

        // Reset wins over start in the same cycle.
        reset = 1'b1; start_c[2] = 1'b1;
        @(negedge clk);
        reset = 1'b0; start_c[2] = 1'b0;
        chk("rst_over_start", {31'd0, busy_c[2]}, 0);
        @(negedge clk);
        chk("rst_over_start2", {31'd0, busy_c[2]}, 0);

        // Random sweeps against the reference model.
        for (int r = 0; r < 12; r++) begin
            int          id = $urandom_range(0, 2);
            logic [15:0] fm = 16'($urandom);
            logic [15:0] em = ($urandom_range(0, 1) == 1) ? fm : 16'($urandom);
            int          ra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : -1;
            do_sweep(model(id, fm, em, ra));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
